// File: rtl/time_keeper_bcd_if.sv
// time_keeper_bcd_if
//  Bundles the control requests and BCD time outputs of time_keeper_bcd.
//  master : the controller side (drives run/set/adjust, reads the time)
//  slave  : the time keeper itself
//  Signals:
//   run_en     1 = time advances
//   set_valid  one-cycle request to load set_time
//   set_time   {h10,h1,m10,m1,s10,s1} BCD, MSB = h10
//   inc_min    one-cycle minute adjust pulse
//   inc_hour   one-cycle hour adjust pulse
//   cnt_*      current BCD digits
//   tick_1hz   one-cycle pulse on the cycle the seconds advanced
//   set_err    one-cycle pulse after a rejected set
interface time_keeper_bcd_if;
    logic        run_en;
    logic        set_valid;
    logic [23:0] set_time;
    logic        inc_min;
    logic        inc_hour;
    logic [3:0]  cnt_sec1;
    logic [3:0]  cnt_sec10;
    logic [3:0]  cnt_min1;
    logic [3:0]  cnt_min10;
    logic [3:0]  cnt_hour1;
    logic [3:0]  cnt_hour10;
    logic        tick_1hz;
    logic        set_err;

    modport master (
        output run_en, set_valid, set_time, inc_min, inc_hour,
        input  cnt_sec1, cnt_sec10, cnt_min1, cnt_min10, cnt_hour1, cnt_hour10,
        input  tick_1hz, set_err
    );

    modport slave (
        input  run_en, set_valid, set_time, inc_min, inc_hour,
        output cnt_sec1, cnt_sec10, cnt_min1, cnt_min10, cnt_hour1, cnt_hour10,
        output tick_1hz, set_err
    );
endinterface

// File: rtl/time_keeper_bcd.sv
// time_keeper_bcd
//  Divides the system clock to a once-per-second tick and keeps a 24-hour
//  hh:mm:ss time of day as six BCD digits. Supports a range-checked atomic
//  load and minute/hour adjust pulses.
//  Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    time_keeper_bcd_if.slave (requests in, digits/tick/set_err out)
//  Parameters:
//   CLK_HZ  clock cycles per second tick
//   PRE_W   prescaler width, 2**PRE_W >= CLK_HZ
module time_keeper_bcd #(
    parameter int CLK_HZ = 25_000_000,
    parameter int PRE_W  = 25
) (
    input  logic              clk,
    input  logic              reset,
    time_keeper_bcd_if.slave  bus
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] prescaler;
    logic [3:0] sec1, sec10, min1, min10, hour1, hour10;
    logic [3:0] sec1_n, sec10_n, min1_n, min10_n, hour1_n, hour10_n;
    logic       tick_q, err_q;

    logic [3:0] set_h10, set_h1, set_m10, set_m1, set_s10, set_s1;
    logic       set_ok, set_load, set_reject;
    logic       wrap, do_hour, do_min, do_tick;

    // Stepped values for each field, used by both the adjust pulses and the
    // tick cascade.
    logic [3:0] sec1_inc, sec10_inc, min1_inc, min10_inc, hour1_inc, hour10_inc;
    logic       sec_carry, min_carry, hour_wrap;

    assign {set_h10, set_h1, set_m10, set_m1, set_s10, set_s1} = bus.set_time;

    assign set_ok = (set_s1 <= 4'd9) && (set_s10 <= 4'd5) &&
                    (set_m1 <= 4'd9) && (set_m10 <= 4'd5) &&
                    (set_h1 <= 4'd9) && (set_h10 <= 4'd2) &&
                    !((set_h10 == 4'd2) && (set_h1 > 4'd3));

    assign set_load   = bus.set_valid && set_ok;
    assign set_reject = bus.set_valid && !set_ok;

    // A rejected set does not block anything below it in priority, so only a
    // successful load masks the adjusts and the tick.
    assign wrap    = bus.run_en && (prescaler == PRE_MAX);
    assign do_hour = bus.inc_hour && !set_load;
    assign do_min  = bus.inc_min && !bus.inc_hour && !set_load;
    assign do_tick = wrap && !bus.inc_min && !bus.inc_hour && !set_load;

    always_comb begin
        sec_carry  = (sec1 == 4'd9) && (sec10 == 4'd5);
        sec1_inc   = (sec1 == 4'd9) ? 4'd0 : sec1 + 4'd1;
        sec10_inc  = (sec1 != 4'd9) ? sec10 : ((sec10 == 4'd5) ? 4'd0 : sec10 + 4'd1);

        min_carry  = (min1 == 4'd9) && (min10 == 4'd5);
        min1_inc   = (min1 == 4'd9) ? 4'd0 : min1 + 4'd1;
        min10_inc  = (min1 != 4'd9) ? min10 : ((min10 == 4'd5) ? 4'd0 : min10 + 4'd1);

        hour_wrap  = (hour10 == 4'd2) && (hour1 == 4'd3);
        hour1_inc  = (hour_wrap || hour1 == 4'd9) ? 4'd0 : hour1 + 4'd1;
        hour10_inc = hour_wrap ? 4'd0 : ((hour1 == 4'd9) ? hour10 + 4'd1 : hour10);
    end

    always_comb begin
        sec1_n   = sec1;
        sec10_n  = sec10;
        min1_n   = min1;
        min10_n  = min10;
        hour1_n  = hour1;
        hour10_n = hour10;
        if (set_load) begin
            {hour10_n, hour1_n, min10_n, min1_n, sec10_n, sec1_n} = bus.set_time;
        end else if (do_hour) begin
            hour1_n  = hour1_inc;
            hour10_n = hour10_inc;
        end else if (do_min) begin
            min1_n  = min1_inc;
            min10_n = min10_inc;
        end else if (do_tick) begin
            sec1_n  = sec1_inc;
            sec10_n = sec10_inc;
            if (sec_carry) begin
                min1_n  = min1_inc;
                min10_n = min10_inc;
                if (min_carry) begin
                    hour1_n  = hour1_inc;
                    hour10_n = hour10_inc;
                end
            end
        end
    end

    // The prescaler wraps whenever it reaches the end of count, even if the
    // resulting tick was discarded by an adjust; only a successful load
    // restarts it so the next tick lands a full second later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            sec1      <= 4'd0;
            sec10     <= 4'd0;
            min1      <= 4'd0;
            min10     <= 4'd0;
            hour1     <= 4'd0;
            hour10    <= 4'd0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (set_load) begin
                prescaler <= '0;
            end else if (bus.run_en) begin
                prescaler <= wrap ? '0 : prescaler + PRE_ONE;
            end
            sec1   <= sec1_n;
            sec10  <= sec10_n;
            min1   <= min1_n;
            min10  <= min10_n;
            hour1  <= hour1_n;
            hour10 <= hour10_n;
            tick_q <= do_tick;
            err_q  <= set_reject;
        end
    end

    assign bus.cnt_sec1   = sec1;
    assign bus.cnt_sec10  = sec10;
    assign bus.cnt_min1   = min1;
    assign bus.cnt_min10  = min10;
    assign bus.cnt_hour1  = hour1;
    assign bus.cnt_hour10 = hour10;
    assign bus.tick_1hz   = tick_q;
    assign bus.set_err    = err_q;

endmodule

// File: tb/tb_time_keeper_bcd.sv
// tb_time_keeper_bcd
//  Self-checking bench for time_keeper_bcd with CLK_HZ = 10.
//  A vector table exercises set/adjust behaviour with the timebase stopped;
//  hand-written sequences cover tick timing, cascades, freeze and reset.
module tb_time_keeper_bcd;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    time_keeper_bcd_if bus ();

    time_keeper_bcd #(
        .CLK_HZ (10),
        .PRE_W  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        set_valid;
        logic [23:0] set_time;
        logic        inc_min;
        logic        inc_hour;
        logic [23:0] exp_time;
        logic        exp_err;
    } vec_t;

    vec_t vecs [21];

    function automatic logic [23:0] cur_time();
        return {bus.cnt_hour10, bus.cnt_hour1, bus.cnt_min10,
                bus.cnt_min1, bus.cnt_sec10, bus.cnt_sec1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [23:0] exp_time,
                               input logic exp_tick, input logic exp_err);
        logic [23:0] t;
        t = cur_time();
        total++;
        if (t !== exp_time) begin
            bad++;
            $display("[TB] FAIL %s time: got %h expected %h", name, t, exp_time);
        end
        total++;
        if (bus.tick_1hz !== exp_tick) begin
            bad++;
            $display("[TB] FAIL %s tick: got %b expected %b", name, bus.tick_1hz, exp_tick);
        end
        total++;
        if (bus.set_err !== exp_err) begin
            bad++;
            $display("[TB] FAIL %s set_err: got %b expected %b", name, bus.set_err, exp_err);
        end
    endtask

    // One request cycle: drive, let one edge sample it, then drop the pulses.
    task automatic applyStimulus(input logic sv, input logic [23:0] st,
                                 input logic im, input logic ih);
        bus.set_valid = sv;
        bus.set_time  = st;
        bus.inc_min   = im;
        bus.inc_hour  = ih;
        step();
        bus.set_valid = 1'b0;
        bus.inc_min   = 1'b0;
        bus.inc_hour  = 1'b0;
    endtask

    // Counts edges up to and including the one that raises tick_1hz.
    task automatic waitTick(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tick_1hz && n < limit);
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int ticks_seen;

        vecs[0]  = '{1'b1, 24'h235930, 1'b0, 1'b0, 24'h235930, 1'b0};
        vecs[1]  = '{1'b0, 24'h000000, 1'b1, 1'b0, 24'h230030, 1'b0};
        vecs[2]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h000030, 1'b0};
        vecs[3]  = '{1'b1, 24'h123456, 1'b0, 1'b0, 24'h123456, 1'b0};
        vecs[4]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 24'h133456, 1'b0};
        vecs[5]  = '{1'b1, 24'h240000, 1'b0, 1'b0, 24'h133456, 1'b1};
        vecs[6]  = '{1'b1, 24'h126A00, 1'b0, 1'b0, 24'h133456, 1'b1};
        vecs[7]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'h133456, 1'b0};
        vecs[8]  = '{1'b1, 24'h234500, 1'b0, 1'b0, 24'h234500, 1'b0};
        vecs[9]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h004500, 1'b0};
        vecs[10] = '{1'b1, 24'h095959, 1'b0, 1'b0, 24'h095959, 1'b0};
        vecs[11] = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h105959, 1'b0};
        vecs[12] = '{1'b1, 24'h190500, 1'b0, 1'b1, 24'h190500, 1'b0};
        vecs[13] = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h200500, 1'b0};
        vecs[14] = '{1'b1, 24'h205907, 1'b1, 1'b0, 24'h205907, 1'b0};
        vecs[15] = '{1'b0, 24'h000000, 1'b1, 1'b0, 24'h200007, 1'b0};
        vecs[16] = '{1'b1, 24'h1F0000, 1'b1, 1'b0, 24'h200107, 1'b1};
        vecs[17] = '{1'b1, 24'h056000, 1'b0, 1'b0, 24'h200107, 1'b1};
        vecs[18] = '{1'b1, 24'h230000, 1'b0, 1'b0, 24'h230000, 1'b0};
        vecs[19] = '{1'b1, 24'h000060, 1'b0, 1'b0, 24'h230000, 1'b1};
        vecs[20] = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h000000, 1'b0};

        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.run_en    = 1'b0;
        bus.set_valid = 1'b0;
        bus.set_time  = 24'h0;
        bus.inc_min   = 1'b0;
        bus.inc_hour  = 1'b0;
        step();
        step();
        checkOutput("reset_state", 24'h000000, 1'b0, 1'b0);
        reset = 1'b0;

        $display("[TB] set/adjust vector table, timebase stopped");
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].set_valid, vecs[i].set_time,
                          vecs[i].inc_min, vecs[i].inc_hour);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_time, 1'b0, vecs[i].exp_err);
        end

        $display("[TB] first tick after reset release and steady period");
        reset = 1'b1;
        #1;
        reset = 1'b0;
        bus.run_en = 1'b1;
        waitTick(40, n);
        checkValue("first_tick_cycles", n, 10);
        checkOutput("first_tick", 24'h000001, 1'b1, 1'b0);
        waitTick(40, n);
        checkValue("second_tick_cycles", n, 10);
        checkOutput("second_tick", 24'h000002, 1'b1, 1'b0);

        $display("[TB] midnight rollover");
        applyStimulus(1'b1, 24'h235958, 1'b0, 1'b0);
        checkOutput("load_235958", 24'h235958, 1'b0, 1'b0);
        waitTick(40, n);
        checkValue("load_tick_cycles", n, 10);
        checkOutput("tick_235959", 24'h235959, 1'b1, 1'b0);
        repeat (9) step();
        checkOutput("hold_235959", 24'h235959, 1'b0, 1'b0);
        step();
        checkOutput("rollover_000000", 24'h000000, 1'b1, 1'b0);

        $display("[TB] hour tens carry");
        applyStimulus(1'b1, 24'h095959, 1'b0, 1'b0);
        waitTick(40, n);
        checkValue("carry_tick_cycles", n, 10);
        checkOutput("carry_100000", 24'h100000, 1'b1, 1'b0);

        $display("[TB] set restarts the prescaler; set beats a tick");
        repeat (7) step();
        applyStimulus(1'b1, 24'h123456, 1'b0, 1'b0);
        checkOutput("load_at_pre7", 24'h123456, 1'b0, 1'b0);
        waitTick(40, n);
        checkValue("tick_after_reload", n, 10);
        checkOutput("tick_123457", 24'h123457, 1'b1, 1'b0);
        repeat (9) step();
        applyStimulus(1'b1, 24'h010203, 1'b0, 1'b0);
        checkOutput("set_vs_tick", 24'h010203, 1'b0, 1'b0);
        waitTick(40, n);
        checkValue("tick_after_set_vs_tick", n, 10);
        checkOutput("tick_010204", 24'h010204, 1'b1, 1'b0);

        $display("[TB] run_en freeze and resume");
        repeat (3) step();
        bus.run_en = 1'b0;
        ticks_seen = 0;
        repeat (25) begin
            step();
            if (bus.tick_1hz) ticks_seen++;
        end
        checkValue("frozen_ticks", ticks_seen, 0);
        checkOutput("frozen_time", 24'h010204, 1'b0, 1'b0);
        bus.run_en = 1'b1;
        waitTick(40, n);
        checkValue("resume_tick_cycles", n, 7);
        checkOutput("resume_010205", 24'h010205, 1'b1, 1'b0);

        $display("[TB] reset mid-count");
        repeat (5) step();
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 24'h000000, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        waitTick(40, n);
        checkValue("post_reset_tick_cycles", n, 10);
        checkOutput("post_reset_000001", 24'h000001, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
